idma_inoc_rd_sched: RTL and testbench
=====================================

# idma_inoc_rd_sched

Job scheduler in front of the iDMA ibuffer read engine. It arbitrates read jobs (word address + word count) from `NUM_REQ` requesters round-robin and launches exactly one job at a time on the engine. It waits for the engine's completion pulse, then reports completion back to the granted requester. It also rejects zero-length and address-wrapping jobs without touching the engine.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8)
- `MEM_AW`, 15: ibuffer line address width
- `WORD_NUM`, 4: 32-bit words per ibuffer line
- `AW`, `MEM_AW+$clog2(WORD_NUM)`: word address width (17)
- `LW`, 13: word-count width
- `IDW`, `$clog2(NUM_REQ)`: requester id width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  job request per requester
- `req_ready`  out  NUM_REQ  one-hot accept pulse
- `req_addr`  in  NUM_REQ*AW  word start address, requester i at slice i
- `req_num`  in  NUM_REQ*LW  word count, requester i at slice i
- `rd_start`  out  1  one-cycle engine launch
- `rd_word_addr`  out  AW  latched start address, stable from START until next accept
- `rd_word_num`  out  LW  latched word count, same stability as `rd_word_addr`
- `eng_done`  in  1  engine last-word-returned pulse
- `busy`  out  1  state != IDLE
- `cur_id`  out  IDW  id of the job in flight
- `done_valid`  out  1  one-cycle completion pulse
- `done_id`  out  IDW  requester of the completed job
- `done_err`  out  1  job rejected (address wrap); qualified by `done_valid`
- `proto_err`  out  1  sticky: `eng_done` seen outside RUN

## Operation
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - If any `req_valid` is high, grant winner g and pulse `req_ready[g]`.
  - Latch addr, num and id.
  - If num==0, go to DONE with `done_err`=0.
  - Else if addr+num-1 overflows AW bits (carry out of AW+1-bit sum), go to DONE with `done_err`=1.
  - Else go to START.
- START: `rd_start`=1 for one cycle → RUN.
- RUN: hold until `eng_done` → DONE.
- DONE: `done_valid`=1 with `done_id`=latched id; update round-robin pointer to g → IDLE.
- Round-robin: search starts at (last_grant+1) mod NUM_REQ. After reset, last_grant=NUM_REQ-1, so requester 0 wins first.
- `req_valid` deasserted before grant: no effect, no state change.
- `eng_done` in IDLE/START/DONE: ignored for sequencing; sets `proto_err` (cleared only by reset).
- Reset mid-job: all state is dropped, no done is reported, and the engine must be reset together with this block.

## Timing
- Reset values: `req_ready`=0, `rd_start`=0, `rd_word_addr`=0, `rd_word_num`=0, `busy`=0, `cur_id`=0, `done_valid`=0, `done_id`=0, `done_err`=0, `proto_err`=0.
- Accept at cycle T (IDLE, combinational `req_ready`) → `rd_start` at T+1.
- `eng_done` at cycle E → `done_valid` at E+1.
- Next accept possible at E+2.
- Rejected or zero-length job: accept T, `done_valid` T+1, next accept T+2.
- `req_ready` depends combinationally on `req_valid` only; it is never high outside IDLE.

## Structure
- Package `idma_inoc_pkg`: FSM state enum, `LW`=13 constant, `WORD_WIDTH`=32.
- Sub-module `idma_inoc_rr_arb`: `NUM_REQ`-way round-robin arbiter.
  - Inputs: request vector, pointer-update enable, granted index.
  - Outputs: one-hot grant and grant index.
  - Pointer register internal.

## Test plan
- Single job, req 2, addr=0x00005, num=7; `eng_done` 10 cycles after `rd_start` → `rd_start` at T+1 with addr 0x00005/num 7; `done_valid` with id 2, err 0, one cycle after `eng_done`.
- All four requesting continuously after reset → grant order 0,1,2,3,0; each `req_ready` one-hot, exactly one `rd_start` per job.
- num=0 from req 1 → no `rd_start`; `done_valid` at T+1 with id 1, err 0.
- addr=0x1FFFE, num=3 → no `rd_start`; `done_valid` at T+1, err 1. addr=0x1FFFE, num=2 → accepted normally.
- `eng_done` pulsed in IDLE, then again in START → `proto_err` rises and stays high; FSM still waits in RUN for a real `eng_done`.
- `rst_n` low while in RUN, then released → all outputs at reset values, no `done_valid`; next grant goes to requester 0.

Source files
------------

// File: rtl/idma_inoc_pkg.sv
// Shared types and constants for the ibuffer read-job scheduler.
// Holds the scheduler FSM encoding and the fixed engine widths.
package idma_inoc_pkg;

    localparam int LW         = 13;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/idma_inoc_rr_arb.sv
// Round-robin arbiter: combinational grant, searching from last_grant+1.
// The pointer moves only when the caller reports a finished grant via upd.
module idma_inoc_rr_arb
    import idma_inoc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd,
    input  logic [IDW-1:0]     upd_idx,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx
);

    logic [IDW-1:0] last_q;

    // Reset to the highest index so requester 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDW'(NUM_REQ - 1);
        end else if (upd) begin
            last_q <= upd_idx;
        end
    end

    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/idma_inoc_rd_sched.sv
// Round-robin read-job scheduler: one job on the engine at a time, accept->start 1 cycle.
// req_ready only pulses in IDLE; completion reported the cycle after eng_done.
module idma_inoc_rd_sched
    import idma_inoc_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MEM_AW   = 15,
    parameter int WORD_NUM = 4,
    parameter int AW       = MEM_AW + $clog2(WORD_NUM),
    parameter int LW       = idma_inoc_pkg::LW,
    parameter int IDW      = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*LW-1:0] req_num,
    output logic                  rd_start,
    output logic [AW-1:0]         rd_word_addr,
    output logic [LW-1:0]         rd_word_num,
    input  logic                  eng_done,
    output logic                  busy,
    output logic [IDW-1:0]        cur_id,
    output logic                  done_valid,
    output logic [IDW-1:0]        done_id,
    output logic                  done_err,
    output logic                  proto_err
);

    state_e             state, state_nxt;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic [AW-1:0]      sel_addr;
    logic [LW-1:0]      sel_num;
    logic [AW:0]        end_addr;
    logic               accept, sel_zero, sel_wrap;
    logic [AW-1:0]      addr_q;
    logic [LW-1:0]      num_q;
    logic [IDW-1:0]     id_q;
    logic               err_q;
    logic               proto_err_q;

    idma_inoc_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .upd     (state == DONE),
        .upd_idx (id_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept   = (state == IDLE) && (|req_valid);
    assign sel_addr = req_addr[int'(gnt_idx)*AW +: AW];
    assign sel_num  = req_num[int'(gnt_idx)*LW +: LW];
    // Last word address with one extra bit; a set MSB means the job wraps.
    assign end_addr = {1'b0, sel_addr} + (AW+1)'(sel_num) - (AW+1)'(1);
    assign sel_zero = (sel_num == '0);
    assign sel_wrap = end_addr[AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (sel_zero || sel_wrap) ? DONE : START;
            START:   state_nxt = RUN;
            RUN:     if (eng_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            num_q  <= '0;
            id_q   <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            addr_q <= sel_addr;
            num_q  <= sel_num;
            id_q   <= gnt_idx;
            // Zero-length jobs complete cleanly even though addr-1 underflows.
            err_q  <= !sel_zero && sel_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_q <= 1'b0;
        end else if (eng_done && (state != RUN)) begin
            proto_err_q <= 1'b1;
        end
    end

    assign req_ready    = (state == IDLE) ? gnt : '0;
    assign rd_start     = (state == START);
    assign rd_word_addr = addr_q;
    assign rd_word_num  = num_q;
    assign busy         = (state != IDLE);
    assign cur_id       = id_q;
    assign done_valid   = (state == DONE);
    assign done_id      = id_q;
    assign done_err     = done_valid && err_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_idma_inoc_rd_sched.sv
// Bench for idma_inoc_rd_sched: vector table, corner sequences, randomized jobs vs a job-level model.
module tb_idma_inoc_rd_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [67:0] req_addr;
    logic [51:0] req_num;
    logic        rd_start;
    logic [16:0] rd_word_addr;
    logic [12:0] rd_word_num;
    logic        eng_done;
    logic        busy;
    logic [1:0]  cur_id;
    logic        done_valid;
    logic [1:0]  done_id;
    logic        done_err;
    logic        proto_err;

    int n_chk = 0;
    int n_err = 0;
    int mdl_last = 3;

    idma_inoc_rd_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_num      (req_num),
        .rd_start     (rd_start),
        .rd_word_addr (rd_word_addr),
        .rd_word_num  (rd_word_num),
        .eng_done     (eng_done),
        .busy         (busy),
        .cur_id       (cur_id),
        .done_valid   (done_valid),
        .done_id      (done_id),
        .done_err     (done_err),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [16:0] addr;
        logic [12:0] num;
        int          dly;
        bit          exp_start;
        bit          exp_err;
    } vec_t;

    vec_t        tbl[9];
    logic [67:0] av;
    logic [51:0] nv;
    logic [3:0]  vld;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Job-level reference: a job wraps if its last word lies beyond the 17-bit space.
    function automatic bit job_wraps(input logic [16:0] a, input logic [12:0] n);
        return (int'(a) + int'(n) - 1) >= (1 << 17);
    endfunction

    // Next winner: first requesting id in the rotation that follows the last served id.
    function automatic int rr_pick(input logic [3:0] v);
        int order[4];
        for (int k = 0; k < 4; k++) order[k] = (mdl_last + 1 + k) % 4;
        foreach (order[k]) if (v[order[k]]) return order[k];
        return 0;
    endfunction

    task automatic randomize_slices();
        for (int i = 0; i < 4; i++) begin
            av[i*17 +: 17] = 17'($urandom());
            nv[i*13 +: 13] = 13'($urandom());
        end
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic drive_job(input logic [3:0] v, input int exp_id, input int dly,
                             input bit exp_start, input bit exp_err, input bit hold);
        logic [16:0] ea;
        logic [12:0] en;
        ea = av[exp_id*17 +: 17];
        en = nv[exp_id*13 +: 13];
        chk("idle_busy", 32'(busy), 32'd0);
        req_valid = v;
        req_addr  = av;
        req_num   = nv;
        #1;
        chk("req_ready_grant", 32'(req_ready), 32'(1) << exp_id);
        mdl_last = exp_id;
        @(negedge clk);
        if (!hold) req_valid = '0;
        chk("ready_low_after_accept", 32'(req_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("rd_start", 32'(rd_start), 32'(exp_start));
        chk("cur_id", 32'(cur_id), 32'(exp_id));
        if (exp_start) begin
            chk("rd_word_addr", 32'(rd_word_addr), 32'(ea));
            chk("rd_word_num", 32'(rd_word_num), 32'(en));
            chk("no_done_in_start", 32'(done_valid), 32'd0);
            repeat (dly) begin
                @(negedge clk);
                chk("run_no_start", 32'(rd_start), 32'd0);
                chk("run_no_done", 32'(done_valid), 32'd0);
                chk("run_ready_low", 32'(req_ready), 32'd0);
            end
            eng_done = 1'b1;
            @(negedge clk);
            eng_done = 1'b0;
        end
        chk("done_valid", 32'(done_valid), 32'd1);
        chk("done_id", 32'(done_id), 32'(exp_id));
        chk("done_err", 32'(done_err), 32'(exp_err));
        chk("done_ready_low", 32'(req_ready), 32'd0);
        chk("done_no_start", 32'(rd_start), 32'd0);
        @(negedge clk);
        chk("idle_no_done", 32'(done_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_num   = '0;
        eng_done  = 1'b0;
        av = '0;
        nv = '0;

        tbl[0] = '{2, 17'h00005, 13'd7,    10, 1'b1, 1'b0};
        tbl[1] = '{1, 17'h00123, 13'd0,    1,  1'b0, 1'b0};
        tbl[2] = '{3, 17'h1FFFE, 13'd3,    1,  1'b0, 1'b1};
        tbl[3] = '{0, 17'h1FFFE, 13'd2,    3,  1'b1, 1'b0};
        tbl[4] = '{2, 17'h00000, 13'd0,    1,  1'b0, 1'b0};
        tbl[5] = '{1, 17'h1FFFF, 13'h1FFF, 1,  1'b0, 1'b1};
        tbl[6] = '{3, 17'h00001, 13'h1FFF, 2,  1'b1, 1'b0};
        tbl[7] = '{0, 17'h1E001, 13'h1FFF, 1,  1'b1, 1'b0};
        tbl[8] = '{1, 17'h1E002, 13'h1FFF, 1,  1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rd_start", 32'(rd_start), 32'd0);
        chk("rst_rd_addr", 32'(rd_word_addr), 32'd0);
        chk("rst_rd_num", 32'(rd_word_num), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur_id", 32'(cur_id), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_done_err", 32'(done_err), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four held valid: strict rotation starting at 0.
        for (int i = 0; i < 4; i++) begin
            av[i*17 +: 17] = 17'(i * 16);
            nv[i*13 +: 13] = 13'(i + 1);
        end
        for (int j = 0; j < 5; j++) drive_job(4'hF, j % 4, 2, 1'b1, 1'b0, 1'b1);
        req_valid = '0;

        for (int t = 0; t < 9; t++) begin
            randomize_slices();
            av[tbl[t].id*17 +: 17] = tbl[t].addr;
            nv[tbl[t].id*13 +: 13] = tbl[t].num;
            vld = 4'(1 << tbl[t].id);
            drive_job(vld, tbl[t].id, tbl[t].dly, tbl[t].exp_start, tbl[t].exp_err, 1'b0);
        end
        chk("proto_clean", 32'(proto_err), 32'd0);

        // Stray eng_done in IDLE and in START: flag only, sequencing unaffected.
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("proto_idle", 32'(proto_err), 32'd1);
        chk("proto_idle_busy", 32'(busy), 32'd0);
        chk("proto_idle_done", 32'(done_valid), 32'd0);
        av[1*17 +: 17] = 17'h00040;
        nv[1*13 +: 13] = 13'd8;
        req_addr  = av;
        req_num   = nv;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        chk("proto_start", 32'(rd_start), 32'd1);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("proto_run_busy", 32'(busy), 32'd1);
        chk("proto_run_no_done", 32'(done_valid), 32'd0);
        repeat (4) @(negedge clk);
        chk("proto_still_run", 32'(busy), 32'd1);
        chk("proto_still_no_done", 32'(done_valid), 32'd0);
        chk("proto_sticky", 32'(proto_err), 32'd1);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("proto_done", 32'(done_valid), 32'd1);
        chk("proto_done_id", 32'(done_id), 32'd1);
        mdl_last = 1;
        @(negedge clk);
        chk("proto_sticky_idle", 32'(proto_err), 32'd1);

        // Reset while RUN: everything dropped, pointer back to its reset position.
        av[2*17 +: 17] = 17'h00100;
        nv[2*13 +: 13] = 13'd4;
        req_addr  = av;
        req_num   = nv;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_start", 32'(rd_start), 32'd0);
        chk("mid_rst_addr", 32'(rd_word_addr), 32'd0);
        chk("mid_rst_num", 32'(rd_word_num), 32'd0);
        chk("mid_rst_cur_id", 32'(cur_id), 32'd0);
        chk("mid_rst_done", 32'(done_valid), 32'd0);
        chk("mid_rst_done_id", 32'(done_id), 32'd0);
        chk("mid_rst_proto", 32'(proto_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = 3;
        @(negedge clk);
        chk("post_rst_done", 32'(done_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        randomize_slices();
        av[0 +: 17] = 17'h00010;
        nv[0 +: 13] = 13'd5;
        drive_job(4'hF, 0, 2, 1'b1, 1'b0, 1'b0);

        // Randomized jobs, expectations from the job-level model.
        for (int r = 0; r < 150; r++) begin
            int          w;
            logic [16:0] a;
            logic [12:0] n;
            bit          wr;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) av[i*17 +: 17] = 17'h1FFFF - 17'($urandom_range(0, 20));
                else av[i*17 +: 17] = 17'($urandom());
                case ($urandom_range(0, 7))
                    0:       nv[i*13 +: 13] = 13'd0;
                    1:       nv[i*13 +: 13] = 13'($urandom());
                    default: nv[i*13 +: 13] = 13'($urandom_range(1, 32));
                endcase
            end
            vld = 4'($urandom_range(1, 15));
            w   = rr_pick(vld);
            a   = av[w*17 +: 17];
            n   = nv[w*13 +: 13];
            wr  = job_wraps(a, n);
            drive_job(vld, w, $urandom_range(1, 5), (n != 0) && !wr, (n != 0) && wr,
                      1'($urandom_range(0, 1)));
        end
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
